// File: rtl/ifetch_if.sv
// ifetch_if: bundle of the fetch-stage instruction-memory, redirect and status signals
interface ifetch_if #(
   parameter int ADDR_W  = 16,
   parameter int INSTR_W = 16
);
   logic [INSTR_W-1:0] instr_i;
   logic               stall_i;
   logic               jump_i;
   logic [ADDR_W-1:0]  jump_target_i;
   logic               branch_i;
   logic [ADDR_W-1:0]  branch_target_i;
   logic [ADDR_W-1:0]  pc_o;
   logic [ADDR_W-2:0]  im_addr_o;
   logic [INSTR_W-1:0] instr_o;
   logic               instr_valid_o;
   logic               halted_o;
   logic               timeout_o;
   logic               misalign_o;
   logic [7:0]         cycle_cnt_o;
   logic [7:0]         retired_cnt_o;
   modport master (
      input  instr_i, stall_i, jump_i, jump_target_i, branch_i, branch_target_i,
      output pc_o, im_addr_o, instr_o, instr_valid_o, halted_o, timeout_o, misalign_o,
             cycle_cnt_o, retired_cnt_o
   );
   modport slave (
      output instr_i, stall_i, jump_i, jump_target_i, branch_i, branch_target_i,
      input  pc_o, im_addr_o, instr_o, instr_valid_o, halted_o, timeout_o, misalign_o,
             cycle_cnt_o, retired_cnt_o
   );
endinterface

// File: rtl/ifetch_halt_ctrl.sv
// ifetch_halt_ctrl: PC sequencer with halt-word drain and cycle watchdog;
// define IFETCH_MISALIGN_TRAP_EN to halt on odd redirect targets instead of clearing bit0
module ifetch_halt_ctrl #(
   parameter int                 ADDR_W    = 16,
   parameter int                 INSTR_W   = 16,
   parameter logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF,
   parameter int                 END_COUNT = 50,
   parameter int                 DRAIN_CYC = 2
) (
   input logic      clk_i,
   input logic      rst_n,
   ifetch_if.master bus
);
   localparam logic [1:0] RUN        = 2'd0;
   localparam logic [1:0] DRAIN      = 2'd1;
   localparam logic [1:0] HALT       = 2'd2;
   localparam logic [7:0] END_C      = 8'(END_COUNT);
   localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYC - 1);
   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, tgt;
   logic [7:0]        drain_q, drain_d, cyc_q, cyc_d, ret_q, ret_d;
   logic              halted_q, halted_d, timeout_q, timeout_d, misalign_q, misalign_d;
   logic              run, is_halt, redir, mis, valid, wd_hit;
   // decode the current fetch: halt word, selected redirect target, trap and watchdog hits
   always_comb begin
      run     = state_q == RUN;
      is_halt = bus.instr_i == HALT_WORD;
      redir   = bus.jump_i | bus.branch_i;
      tgt     = bus.jump_i ? bus.jump_target_i : bus.branch_target_i;
`ifdef IFETCH_MISALIGN_TRAP_EN
      mis     = run && !bus.stall_i && !is_halt && redir && tgt[0];
`else
      mis     = 1'b0;
      tgt[0]  = 1'b0;
`endif
      valid   = rst_n && run && !bus.stall_i && !is_halt && !mis;
      wd_hit  = run && (cyc_q + 8'd1 == END_C);
   end
   // next-state: halt word wins over the watchdog, stall freezes pc but still burns budget
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      drain_d    = drain_q;
      halted_d   = halted_q;
      timeout_d  = timeout_q;
      misalign_d = misalign_q;
      cyc_d      = (state_q != HALT && cyc_q != 8'hFF) ? cyc_q + 8'd1 : cyc_q;
      ret_d      = (valid && ret_q != 8'hFF) ? ret_q + 8'd1 : ret_q;
      if (run) begin
         if (!bus.stall_i && is_halt) begin
            state_d = DRAIN;
            drain_d = '0;
         end else begin
            if (!bus.stall_i && !mis) pc_d = redir ? tgt : pc_q + ADDR_W'(2);
            if (mis) begin
               state_d    = HALT;
               halted_d   = 1'b1;
               misalign_d = 1'b1;
            end
            if (wd_hit) begin
               state_d   = HALT;
               halted_d  = 1'b1;
               timeout_d = 1'b1;
            end
         end
      end else if (state_q == DRAIN) begin
         drain_d = drain_q + 8'd1;
         if (drain_q == DRAIN_LAST) begin
            state_d  = HALT;
            halted_d = 1'b1;
         end
      end
   end
   // state registers, cleared asynchronously from any state
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         pc_q       <= '0;
         drain_q    <= '0;
         cyc_q      <= '0;
         ret_q      <= '0;
         halted_q   <= 1'b0;
         timeout_q  <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         drain_q    <= drain_d;
         cyc_q      <= cyc_d;
         ret_q      <= ret_d;
         halted_q   <= halted_d;
         timeout_q  <= timeout_d;
         misalign_q <= misalign_d;
      end
   end
   assign bus.pc_o          = pc_q;
   assign bus.im_addr_o     = pc_q[ADDR_W-1:1];
   assign bus.instr_o       = bus.instr_i;
   assign bus.instr_valid_o = valid;
   assign bus.halted_o      = halted_q;
   assign bus.timeout_o     = timeout_q;
   assign bus.misalign_o    = misalign_q;
   assign bus.cycle_cnt_o   = cyc_q;
   assign bus.retired_cnt_o = ret_q;
endmodule

// File: tb/tb_ifetch_halt_ctrl.sv
// tb_ifetch_halt_ctrl: directed scenarios checked every cycle against a behavioural fetch model
module tb_ifetch_halt_ctrl;
`ifdef IFETCH_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif
   localparam int END_COUNT = 50;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        chk_en = 1'b0;
   logic [15:0] im [0:255];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] m_pc = '0;
   int          m_cyc = 0, m_ret = 0, m_drain_left = 0;
   bit          m_halted = 0, m_to = 0, m_mis = 0;
   logic [15:0] s_w, s_tgt;
   bit          s_redir;

   ifetch_if ifc ();
   ifetch_halt_ctrl dut (.clk_i(clk), .rst_n(rst_n), .bus(ifc.master));

   assign ifc.instr_i = im[ifc.im_addr_o[7:0]];

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit exp_valid();
      logic [15:0] w, t;
      bit r;
      w = im[m_pc[8:1]];
      r = ifc.jump_i | ifc.branch_i;
      t = ifc.jump_i ? ifc.jump_target_i : ifc.branch_target_i;
      return rst_n && !m_halted && m_drain_left == 0 && !ifc.stall_i && w != 16'hFFFF
             && !(TRAP && r && t[0]);
   endfunction

   // behavioural model: advances one rising edge of fetch, or clears on reset
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_pc = '0; m_cyc = 0; m_ret = 0; m_drain_left = 0;
         m_halted = 0; m_to = 0; m_mis = 0;
      end else if (!m_halted) begin
         s_w = im[m_pc[8:1]];
         if (m_cyc < 255) m_cyc++;
         if (m_drain_left > 0) begin
            m_drain_left--;
            if (m_drain_left == 0) m_halted = 1;
         end else if (ifc.stall_i) begin
            if (m_cyc == END_COUNT) begin m_halted = 1; m_to = 1; end
         end else if (s_w == 16'hFFFF) begin
            m_drain_left = 2;
         end else begin
            s_redir = ifc.jump_i | ifc.branch_i;
            s_tgt   = ifc.jump_i ? ifc.jump_target_i : ifc.branch_target_i;
            if (TRAP && s_redir && s_tgt[0]) begin
               m_halted = 1; m_mis = 1;
            end else begin
               m_pc = s_redir ? (s_tgt & 16'hFFFE) : m_pc + 16'd2;
               if (m_ret < 255) m_ret++;
            end
            if (m_cyc == END_COUNT) begin m_halted = 1; m_to = 1; end
         end
      end
   end

   // per-cycle comparison of every output against the model
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("pc", ifc.pc_o, m_pc);
         chk("im_addr", ifc.im_addr_o, m_pc[15:1]);
         chk("instr", ifc.instr_o, im[m_pc[8:1]]);
         chk("valid", ifc.instr_valid_o, exp_valid());
         chk("halted", ifc.halted_o, m_halted);
         chk("timeout", ifc.timeout_o, m_to);
         chk("misalign", ifc.misalign_o, m_mis);
         chk("cycle_cnt", ifc.cycle_cnt_o, m_cyc);
         chk("retired_cnt", ifc.retired_cnt_o, m_ret);
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic fill(input bit with_halt);
      for (int i = 0; i < 256; i++) im[i] = 16'h1000 + 16'(i);
      if (with_halt) im[4] = 16'hFFFF;
   endtask

   task automatic do_reset(input bit pin);
      ifc.stall_i = 0; ifc.jump_i = 0; ifc.branch_i = 0;
      ifc.jump_target_i = '0; ifc.branch_target_i = '0;
      rst_n = 0;
      #1 chk_en = 1;
      cyc(2);
      if (pin) begin
         chk("rst_pc", ifc.pc_o, 0);
         chk("rst_valid", ifc.instr_valid_o, 0);
         chk("rst_halted", ifc.halted_o, 0);
         chk("rst_cycle", ifc.cycle_cnt_o, 0);
      end
      rst_n = 1;
   endtask

   initial begin
      fill(1);
      #1;
      // straight-line run into the halt word
      do_reset(1);
      cyc(4);
      chk("sl_pc", ifc.pc_o, 16'd8);
      chk("sl_ret", ifc.retired_cnt_o, 4);
      chk("sl_valid_at_halt", ifc.instr_valid_o, 0);
      cyc(2);
      chk("sl_not_yet_halted", ifc.halted_o, 0);
      cyc(1);
      chk("sl_halted", ifc.halted_o, 1);
      chk("sl_cycle", ifc.cycle_cnt_o, 7);
      cyc(3);
      chk("sl_frozen_pc", ifc.pc_o, 16'd8);
      chk("sl_frozen_cycle", ifc.cycle_cnt_o, 7);
      // redirect priority
      fill(0);
      do_reset(0);
      cyc(2);
      ifc.jump_i = 1; ifc.jump_target_i = 16'h0010;
      ifc.branch_i = 1; ifc.branch_target_i = 16'h0020;
      cyc(1);
      chk("jump_over_branch", ifc.pc_o, 16'h0010);
      ifc.jump_i = 0;
      cyc(1);
      chk("branch_only", ifc.pc_o, 16'h0020);
      ifc.branch_i = 0;
      cyc(2);
      // stall beats jump
      do_reset(0);
      cyc(3);
      ifc.stall_i = 1; ifc.jump_i = 1; ifc.jump_target_i = 16'h0040;
      cyc(3);
      chk("stall_pc", ifc.pc_o, 16'd6);
      chk("stall_valid", ifc.instr_valid_o, 0);
      chk("stall_ret", ifc.retired_cnt_o, 3);
      chk("stall_cycle", ifc.cycle_cnt_o, 6);
      ifc.stall_i = 0; ifc.jump_i = 0;
      cyc(1);
      chk("stall_release_pc", ifc.pc_o, 16'd8);
      // watchdog on a two-instruction loop
      do_reset(0);
      for (int i = 0; i < 60; i++) begin
         ifc.jump_i = (i % 2) != 0; ifc.jump_target_i = '0;
         cyc(1);
         if (i == 48) chk("wd_early_halted", ifc.halted_o, 0);
         if (i == 49) begin
            chk("wd_halted", ifc.halted_o, 1);
            chk("wd_timeout", ifc.timeout_o, 1);
         end
      end
      chk("wd_cycle_frozen", ifc.cycle_cnt_o, 50);
      // asynchronous reset during drain
      fill(1);
      do_reset(0);
      cyc(6);
      #2 rst_n = 0;
      #1;
      chk("async_pc", ifc.pc_o, 0);
      chk("async_cycle", ifc.cycle_cnt_o, 0);
      chk("async_ret", ifc.retired_cnt_o, 0);
      chk("async_valid", ifc.instr_valid_o, 0);
      @(posedge clk); #1 rst_n = 1;
      cyc(1);
      chk("restart_pc", ifc.pc_o, 16'd2);
      // pc wrap
      fill(0);
      do_reset(0);
      ifc.jump_i = 1; ifc.jump_target_i = 16'hFFFE;
      cyc(1);
      chk("wrap_top", ifc.pc_o, 16'hFFFE);
      ifc.jump_i = 0;
      cyc(1);
      chk("wrap_zero", ifc.pc_o, 16'h0000);
      // odd redirect target
      do_reset(0);
      cyc(1);
      ifc.branch_i = 1; ifc.branch_target_i = 16'h0013;
      if (TRAP) chk("mis_valid", ifc.instr_valid_o, 0);
      cyc(1);
      ifc.branch_i = 0;
      if (TRAP) begin
         chk("mis_flag", ifc.misalign_o, 1);
         chk("mis_halted", ifc.halted_o, 1);
         chk("mis_pc", ifc.pc_o, 16'd2);
         chk("mis_ret", ifc.retired_cnt_o, 1);
      end else begin
         chk("mask_pc", ifc.pc_o, 16'h0012);
         chk("mask_flag", ifc.misalign_o, 0);
      end
      cyc(2);
      @(negedge clk); #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
